// File: rtl/servile_spi_mem.sv
// servile_spi_mem: Wishbone-classic slave bridging the servile shared memory
// port to a 23LC1024-style serial SRAM (sequential mode, SPI mode 0).
// Each bus access becomes one SPI frame: command, address, data bytes.
//
// state | meaning
// IDLE  | waiting for stb; on stb the whole frame is latched into the shifter
// SHIFT | cs_n low, clocking the frame out MSB first, sampling miso
// DONE  | one-cycle ack, cs_n high, rdt updated on reads
// GAP   | one idle cycle so a still-high stb does not retrigger
module servile_spi_mem #(
  parameter int SCK_DIV = 1,
  parameter int ADR_W   = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_mem_adr,
  input  logic [31:0] i_wb_mem_dat,
  input  logic [3:0]  i_wb_mem_sel,
  input  logic        i_wb_mem_we,
  input  logic        i_wb_mem_stb,
  output logic [31:0] o_wb_mem_rdt,
  output logic        o_wb_mem_ack,
  output logic        o_spi_cs_n,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int FW = 8 + ADR_W + 32;
  localparam int CW = $clog2(FW + 1);
  localparam logic [7:0] DIV_END = 8'(SCK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t        r_state;
  logic [FW-1:0] r_shreg;
  logic [CW-1:0] r_bits;
  logic [7:0]    r_div;
  logic [31:0]   r_rx;
  logic          r_we;
  logic          r_cs_n;
  logic          r_sclk;
  logic          r_mosi;
  logic          r_ack;
  logic [31:0]   r_rdt;

  logic [1:0]    w_low_lane;
  logic [2:0]    w_popcnt;
  logic [1:0]    w_s;
  logic [2:0]    w_n;
  logic [31:0]   w_lanes;
  logic [31:0]   w_data;
  logic [FW-1:0] w_frame;
  logic [CW-1:0] w_nbits;
  logic          w_unused;

  // Upper address bits beyond the SPI address and the byte offset are not used.
  assign w_unused = ^{i_wb_mem_adr[31:ADR_W], i_wb_mem_adr[1:0]};

  // Lane calculation: start lane and byte count of the request, frame image.
  always_comb begin
    w_low_lane = 2'd0;
    casez (i_wb_mem_sel)
      4'b???1: w_low_lane = 2'd0;
      4'b??10: w_low_lane = 2'd1;
      4'b?100: w_low_lane = 2'd2;
      4'b1000: w_low_lane = 2'd3;
      default: w_low_lane = 2'd0;
    endcase
    w_popcnt = 3'(i_wb_mem_sel[0]) + 3'(i_wb_mem_sel[1]) +
               3'(i_wb_mem_sel[2]) + 3'(i_wb_mem_sel[3]);
    w_s      = i_wb_mem_we ? w_low_lane : 2'd0;
    w_n      = i_wb_mem_we ? w_popcnt : 3'd4;
    // Data bytes go out lowest lane first, so shift lane s down and byte-reverse.
    w_lanes  = i_wb_mem_dat >> {w_s, 3'b000};
    w_data   = i_wb_mem_we ? {w_lanes[7:0], w_lanes[15:8], w_lanes[23:16], w_lanes[31:24]}
                           : 32'h0;
    w_frame  = {(i_wb_mem_we ? 8'h02 : 8'h03), i_wb_mem_adr[ADR_W-1:2], w_s, w_data};
    w_nbits  = CW'(8 + ADR_W) + CW'({w_n, 3'b000});
  end

  // Main sequencer: frame load, SCLK generation, bit shifting, ack and read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_bits  <= '0;
      r_div   <= '0;
      r_rx    <= '0;
      r_we    <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ack   <= 1'b0;
      r_rdt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_wb_mem_stb) begin
            r_we  <= i_wb_mem_we;
            r_div <= '0;
            if (i_wb_mem_we && (i_wb_mem_sel == 4'b0000)) begin
              r_state <= DONE;
              r_ack   <= 1'b1;
            end else begin
              r_state <= SHIFT;
              r_cs_n  <= 1'b0;
              r_mosi  <= w_frame[FW-1];
              r_shreg <= {w_frame[FW-2:0], 1'b0};
              r_bits  <= w_nbits;
            end
          end
        end
        SHIFT: begin
          if (r_div == DIV_END) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[30:0], i_spi_miso};
            end else begin
              r_sclk <= 1'b0;
              r_bits <= r_bits - CW'(1);
              if (r_bits == CW'(1)) begin
                r_state <= DONE;
                r_cs_n  <= 1'b1;
                r_mosi  <= 1'b0;
                r_ack   <= 1'b1;
                // Last 32 received bits are the data; first byte lands in [7:0].
                if (!r_we) r_rdt <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
              end else begin
                r_mosi  <= r_shreg[FW-1];
                r_shreg <= {r_shreg[FW-2:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        DONE: begin
          r_ack   <= 1'b0;
          r_state <= GAP;
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wb_mem_rdt = r_rdt;
  assign o_wb_mem_ack = r_ack;
  assign o_spi_cs_n   = r_cs_n;
  assign o_spi_sclk   = r_sclk;
  assign o_spi_mosi   = r_mosi;

endmodule
